// File: rtl/aes_pkg.sv
// Shared AES byte/column/state types and GF(2^8) constant-multiply helpers.
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] column_t;
    typedef byte_t [15:0] state_t;

    localparam byte_t AES_POLY = 8'h1B;

    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Coefficients up to 0x0f are enough for both MixColumns and InvMixColumns.
    function automatic byte_t gmul_const(input byte_t x, input logic [3:0] coeff);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (coeff[0] ? x  : 8'h00) ^
               (coeff[1] ? x2 : 8'h00) ^
               (coeff[2] ? x4 : 8'h00) ^
               (coeff[3] ? x8 : 8'h00);
    endfunction

    // Coefficient applied to input row j when producing output row r, with pos = (j - r) mod 4.
    function automatic logic [3:0] row_coeff(input logic inverse, input logic [1:0] pos);
        logic [3:0] c;
        case (pos)
            2'd0:    c = inverse ? 4'he : 4'h2;
            2'd1:    c = inverse ? 4'hb : 4'h3;
            2'd2:    c = inverse ? 4'hd : 4'h1;
            default: c = inverse ? 4'h9 : 4'h1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 4-byte column.
module mix_single_column
    import aes_pkg::*;
(
    input  column_t col,
    input  logic    inverse,
    output column_t mixed
);

    always_comb begin
        mixed = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                mixed[r] = mixed[r] ^ gmul_const(col[j], row_coeff(inverse, 2'(j - r)));
            end
        end
    end

endmodule

// File: rtl/transform_columns.sv
// AES MixColumns / InvMixColumns over a full state, one state per cycle, registered output.
module transform_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         inverse,
    input  logic [127:0] in_state,
    output logic         out_valid,
    output logic [127:0] out_state
);

    state_t in_bytes;
    state_t mixed;
    state_t state_q;
    logic   valid_q;

    assign in_bytes = state_t'(in_state);

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_mix (
            .col     (column_t'(in_bytes[4*c +: 4])),
            .inverse (inverse),
            .mixed   (mixed[4*c +: 4])
        );
    end

    // Valid semantics: no backpressure; every cycle with in_valid=1 yields a result
    // one cycle later with out_valid=1. Idle cycles drop out_valid but hold out_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                state_q <= mixed;
            end
        end
    end

    assign out_state = 128'(state_q);
    assign out_valid = valid_q;

endmodule

// File: tb/tb_transform_columns.sv
// Directed and random checks of transform_columns against an independent GF(2^8) model.
module tb_transform_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inverse;
    logic [127:0] in_state;
    logic         out_valid;
    logic [127:0] out_state;

    logic [127:0] exp_q[$];
    logic [127:0] last_out;
    int           total;
    int           bad;

    transform_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inverse   (inverse),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [7:0]   fw [4];
        logic [7:0]   iv [4];
        logic [7:0]   a  [4];
        logic [7:0]   acc;
        logic [127:0] res;
        fw = '{8'h02, 8'h03, 8'h01, 8'h01};
        iv = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = st[32*c + 8*j +: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gm(a[j], inv ? iv[(j - r + 4) % 4] : fw[(j - r + 4) % 4]);
                res[32*c + 8*r +: 8] = acc;
            end
        end
        return res;
    endfunction

    // Column written in reading order a0 a1 a2 a3; a0 lands in the low byte.
    function automatic logic [31:0] col(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        return {col(c3), col(c2), col(c1), col(c0)};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_out(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, push the expected result, then check after the edge.
    task automatic step(input string tag, input logic v, input logic inv,
                        input logic [127:0] st, input logic [127:0] exp);
        logic [127:0] want;
        in_valid = v;
        inverse  = inv;
        in_state = st;
        if (v) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_bit({tag, "_valid"}, out_valid, v);
        if (v) begin
            if (exp_q.size() == 0) begin
                want = 'x;
                check_out({tag, "_empty_queue"}, out_state, want);
            end else begin
                want = exp_q.pop_front();
                check_out(tag, out_state, want);
                last_out = want;
            end
        end else begin
            check_out({tag, "_held"}, out_state, last_out);
        end
    endtask

    logic [127:0] s1_in, s1_out, s2_in, s2_out, inv_cols, r0, r1, r2;

    initial begin
        total    = 0;
        bad      = 0;
        last_out = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inverse  = 1'b0;
        in_state = '0;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", out_state, 128'h0);
        check_bit("reset_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s1_in  = mk(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        s1_out = mk(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c);
        s2_in  = mk(32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5);
        s2_out = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6);
        inv_cols = mk(32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6);

        step("fips_fwd", 1'b1, 1'b0, s1_in, s1_out);
        step("fips_inv", 1'b1, 1'b1, s1_out, s1_in);
        step("vec2_fwd", 1'b1, 1'b0, s2_in, s2_out);
        step("vec2_inv", 1'b1, 1'b1, s2_out, s2_in);
        step("invariant_fwd", 1'b1, 1'b0, inv_cols, inv_cols);
        step("invariant_inv", 1'b1, 1'b1, inv_cols, inv_cols);

        r0 = rnd128();
        r1 = rnd128();
        r2 = rnd128();
        step("stream0", 1'b1, 1'b0, r0, model(r0, 1'b0));
        step("stream1", 1'b1, 1'b1, r1, model(r1, 1'b1));
        step("stream2", 1'b1, 1'b0, r2, model(r2, 1'b0));
        step("idle0", 1'b0, 1'b1, rnd128(), '0);
        step("idle1", 1'b0, 1'b0, rnd128(), '0);

        // Reset asserted between edges while a transfer is in flight.
        in_valid = 1'b1;
        inverse  = 1'b0;
        in_state = s2_in;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_state", out_state, 128'h0);
        check_bit("async_reset_valid", out_valid, 1'b0);
        exp_q.delete();
        last_out = '0;
        @(posedge clk);
        #1;
        check_out("reset_hold_state", out_state, 128'h0);
        rst_n = 1'b1;
        step("after_reset", 1'b1, 1'b0, s1_in, s1_out);

        for (int i = 0; i < 1000; i++) begin
            r0 = rnd128();
            r1 = model(r0, 1'b0);
            step("rand_fwd", 1'b1, 1'b0, r0, r1);
            step("rand_roundtrip", 1'b1, 1'b1, r1, r0);
            if ($urandom_range(0, 3) == 0)
                step("rand_inv", 1'b1, 1'b1, r0, model(r0, 1'b1));
            if ($urandom_range(0, 7) == 0)
                step("rand_idle", 1'b0, 1'($urandom_range(0, 1)), rnd128(), '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
